// File: rtl/mem_resp_model.sv
// mem_resp_model: fetch + data request/response memory model sharing one word array.
// Optional MEM_STARTUP_DELAY_EN holds both request readies low for STARTUP_CYCLES after reset.

module mem_resp_chan #(
   parameter int DATA_W      = 32,
   parameter int LATENCY     = 1,
   parameter int OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc,
   input  logic [DATA_W-1:0] acc_data,
   input  logic              resp_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              slot_free
);
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] fifo_q [OUTSTANDING];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_cnt;
   logic [CW-1:0]     flight_cnt;

   // The FIFO write itself is the last latency stage.
   generate
      if (LATENCY == 1) begin : g_direct
         assign push      = acc;
         assign push_data = acc_data;
      end else begin : g_pipe
         logic [LATENCY-2:0] pipe_v;
         logic [DATA_W-1:0]  pipe_d [LATENCY-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_v <= '0;
            end else begin
               pipe_v[0] <= acc;
               for (int i = 1; i < LATENCY - 1; i++)
                  pipe_v[i] <= pipe_v[i-1];
            end
         end

         always_ff @(posedge clk) begin
            pipe_d[0] <= acc_data;
            for (int i = 1; i < LATENCY - 1; i++)
               pipe_d[i] <= pipe_d[i-1];
         end

         assign push      = pipe_v[LATENCY-2];
         assign push_data = pipe_d[LATENCY-2];
      end
   endgenerate

   assign resp_valid = (fifo_cnt != '0);
   assign resp_data  = resp_valid ? fifo_q[rd_ptr] : '0;
   assign pop        = resp_valid && resp_ready;
   assign slot_free  = (flight_cnt < CW'(OUTSTANDING));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         flight_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
         fifo_cnt   <= fifo_cnt + CW'(push) - CW'(pop);
         flight_cnt <= flight_cnt + CW'(acc) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr] <= push_data;
   end
endmodule

module mem_resp_model #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int DEPTH          = 256,
   parameter int LATENCY        = 1,
   parameter int OUTSTANDING    = 4,
   parameter int STARTUP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [ADDR_W-1:0]     i_req_addr,
   output logic                  i_resp_valid,
   input  logic                  i_resp_ready,
   output logic [DATA_W-1:0]     i_resp_data,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [ADDR_W-1:0]     d_req_addr,
   input  logic [DATA_W-1:0]     d_req_wdata,
   input  logic [DATA_W/8-1:0]   d_req_be,
   output logic                  d_resp_valid,
   input  logic                  d_resp_ready,
   output logic [DATA_W-1:0]     d_resp_data
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IW-1:0]     i_idx;
   logic [IW-1:0]     d_idx;
   logic              run;
   logic              i_free;
   logic              d_free;
   logic              i_acc;
   logic              d_rd;
   logic              d_wr;
   logic              unused_addr;

   assign i_idx       = i_req_addr[OFF +: IW];
   assign d_idx       = d_req_addr[OFF +: IW];
   assign unused_addr = ^{i_req_addr, d_req_addr};

`ifdef MEM_STARTUP_DELAY_EN
   localparam int SW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
   logic [SW-1:0] su_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         su_cnt <= '0;
      else if (su_cnt != SW'(STARTUP_CYCLES))
         su_cnt <= su_cnt + SW'(1);
   end

   assign run = rst_n && (su_cnt == SW'(STARTUP_CYCLES));
`else
   assign run = rst_n;
`endif

   // Writes never occupy an in-flight slot, so only reads see the count.
   assign i_req_ready = run && i_free;
   assign d_req_ready = run && (d_req_we || d_free);
   assign i_acc       = i_req_valid && i_req_ready;
   assign d_rd        = d_req_valid && d_req_ready && !d_req_we;
   assign d_wr        = d_req_valid && d_req_ready && d_req_we;

   always_ff @(posedge clk) begin
      if (d_wr) begin
         for (int b = 0; b < BYTES; b++)
            if (d_req_be[b])
               mem[d_idx][b*8 +: 8] <= d_req_wdata[b*8 +: 8];
      end
   end

   mem_resp_chan #(
      .DATA_W      (DATA_W),
      .LATENCY     (LATENCY),
      .OUTSTANDING (OUTSTANDING)
   ) u_ichan (
      .clk        (clk),
      .rst_n      (rst_n),
      .acc        (i_acc),
      .acc_data   (mem[i_idx]),
      .resp_ready (i_resp_ready),
      .resp_valid (i_resp_valid),
      .resp_data  (i_resp_data),
      .slot_free  (i_free)
   );

   mem_resp_chan #(
      .DATA_W      (DATA_W),
      .LATENCY     (LATENCY),
      .OUTSTANDING (OUTSTANDING)
   ) u_dchan (
      .clk        (clk),
      .rst_n      (rst_n),
      .acc        (d_rd),
      .acc_data   (mem[d_idx]),
      .resp_ready (d_resp_ready),
      .resp_valid (d_resp_valid),
      .resp_data  (d_resp_data),
      .slot_free  (d_free)
   );
endmodule

// File: tb/tb_mem_resp_model.sv
// tb_mem_resp_model: random + directed traffic checked against a queue-based
// timestamped reference model of both channels.

module tb_mem_resp_model;
   localparam int LAT = 3;
   localparam int OUT = 2;
   localparam int DEP = 16;
`ifdef MEM_STARTUP_DELAY_EN
   localparam int SU_NEED = 1;
`else
   localparam int SU_NEED = 0;
`endif

   typedef struct {
      logic [31:0] data;
      int          at;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv = 1'b0, irr = 1'b0;
   logic [31:0] ia = '0;
   logic        dv = 1'b0, dwe = 1'b0, drr = 1'b0;
   logic [31:0] da = '0, dwd = '0;
   logic [3:0]  dbe = '0;
   logic        i_req_ready, i_resp_valid, d_req_ready, d_resp_valid;
   logic [31:0] i_resp_data, d_resp_data;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          su = 0;
   int          n_dacc = 0;
   logic [31:0] last_i = '0, last_d = '0;
   logic [31:0] mm [DEP];
   ent_t        qi[$];
   ent_t        qd[$];

   always #5 clk = ~clk;

   mem_resp_model #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .LATENCY(LAT),
      .OUTSTANDING(OUT), .STARTUP_CYCLES(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(iv), .i_req_ready(i_req_ready), .i_req_addr(ia),
      .i_resp_valid(i_resp_valid), .i_resp_ready(irr),
      .i_resp_data(i_resp_data),
      .d_req_valid(dv), .d_req_ready(d_req_ready), .d_req_we(dwe),
      .d_req_addr(da), .d_req_wdata(dwd), .d_req_be(dbe),
      .d_resp_valid(d_resp_valid), .d_resp_ready(drr),
      .d_resp_data(d_resp_data)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEP);
   endfunction

   task automatic drive(input logic iv_, input logic [31:0] ia_,
                        input logic irr_, input logic dv_, input logic dwe_,
                        input logic [31:0] da_, input logic [31:0] dwd_,
                        input logic [3:0] dbe_, input logic drr_);
      iv = iv_; ia = ia_; irr = irr_;
      dv = dv_; dwe = dwe_; da = da_; dwd = dwd_; dbe = dbe_; drr = drr_;
   endtask

   // One clock: check outputs against the model, then advance the model.
   task automatic step();
      bit   run, eri, erd, evi, evd;
      ent_t e;
      int   w;
      #1;
      run = (su >= SU_NEED);
      eri = run && (qi.size() < OUT);
      erd = run && (dwe || (qd.size() < OUT));
      evi = (qi.size() > 0) && (qi[0].at <= cyc);
      evd = (qd.size() > 0) && (qd[0].at <= cyc);
      chk("i_req_ready", {31'd0, i_req_ready}, {31'd0, eri});
      chk("d_req_ready", {31'd0, d_req_ready}, {31'd0, erd});
      chk("i_resp_valid", {31'd0, i_resp_valid}, {31'd0, evi});
      chk("d_resp_valid", {31'd0, d_resp_valid}, {31'd0, evd});
      if (evi) chk("i_resp_data", i_resp_data, qi[0].data);
      if (evd) chk("d_resp_data", d_resp_data, qd[0].data);
      if (dv && !dwe && d_req_ready) n_dacc++;
      if (evi && irr) begin
         last_i = i_resp_data;
         void'(qi.pop_front());
      end
      if (evd && drr) begin
         last_d = d_resp_data;
         void'(qd.pop_front());
      end
      if (iv && eri) begin
         e.data = mm[widx(ia)];
         e.at   = cyc + LAT;
         qi.push_back(e);
      end
      if (dv && erd && !dwe) begin
         e.data = mm[widx(da)];
         e.at   = cyc + LAT;
         qd.push_back(e);
      end
      if (dv && erd && dwe) begin
         w = widx(da);
         for (int b = 0; b < 4; b++)
            if (dbe[b]) mm[w][b*8 +: 8] = dwd[b*8 +: 8];
      end
      @(posedge clk);
      cyc++;
      su++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
      repeat (n) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_i_req_ready", {31'd0, i_req_ready}, 32'd0);
      chk("rst_d_req_ready", {31'd0, d_req_ready}, 32'd0);
      chk("rst_i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
      chk("rst_d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
      chk("rst_i_resp_data", i_resp_data, 32'd0);
      chk("rst_d_resp_data", d_resp_data, 32'd0);
      qi.delete();
      qd.delete();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      su = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      step();
      // Preload every word through the data port.
      for (int k = 0; k < DEP; k++) begin
         logic [31:0] v;
         v = $urandom;
         if (k == 0) v = 32'h12345678;
         if (k == 1) v = 32'h0;
         if (k == 5) v = 32'hAAAA5555;
         drive(0, 0, 1, 1, 1, 32'(k * 4), v, 4'hf, 1);
         step();
      end

      drive(1, 32'h0, 1, 0, 0, 0, 0, 0, 1);
      step();
      idle(6);
      chk("fetch_word0", last_i, 32'h12345678);

      drive(0, 0, 1, 1, 1, 32'h4, 32'hDEADBEEF, 4'b0011, 1);
      step();
      drive(0, 0, 1, 1, 0, 32'h4, 0, 0, 1);
      step();
      chk("be_read_first", d_resp_valid ? 32'd1 : 32'd0, 32'd0);
      drive(0, 0, 1, 1, 0, 32'h4, 0, 0, 1);
      step();
      idle(2);
      chk("be_read_a", last_d, 32'h0000BEEF);
      idle(4);
      chk("be_read_b", last_d, 32'h0000BEEF);

      n_dacc = 0;
      drive(0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
      repeat (6) step();
      chk("full_accepts", 32'(n_dacc), 32'd2);
      chk("full_ready_low", {31'd0, d_req_ready}, 32'd0);
      idle(8);
      chk("drain_last", last_d, 32'h12345678);

      drive(1, 32'd20, 1, 1, 1, 32'd20, 32'h0BADF00D, 4'hf, 1);
      step();
      idle(6);
      chk("fetch_old", last_i, 32'hAAAA5555);
      drive(1, 32'd20, 1, 0, 0, 0, 0, 0, 1);
      step();
      idle(6);
      chk("fetch_new", last_i, 32'h0BADF00D);

      last_i = '0;
      drive(1, 32'h400, 1, 0, 0, 0, 0, 0, 1);
      step();
      idle(6);
      chk("alias_0x400", last_i, 32'h12345678);
      last_i = '0;
      drive(1, 32'h43, 1, 0, 0, 0, 0, 0, 1);
      step();
      idle(6);
      chk("alias_0x43", last_i, 32'h12345678);

      drive(0, 0, 0, 1, 0, 32'h8, 0, 0, 0);
      repeat (2) step();
      do_reset();
      idle(10);

      for (int n = 0; n < 1500; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 32'h7ff),
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 1), $urandom_range(0, 2) == 0,
               $urandom_range(0, 32'h7ff), $urandom, 4'($urandom),
               $urandom_range(0, 9) < 7);
         step();
      end
      idle(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_resp_model.md
# mem_resp_model

Parametrised, synthesizable two-channel memory responder for core-level benches and FPGA bring-up. It replaces ad-hoc `force`-driven memory stubs with a proper request/response block: an instruction-fetch read channel and a data read/write channel sharing one word array. Each channel has a configurable response latency, bounded outstanding requests and response back-pressure. It sits between the core's `imem_*` and `mem_*` ports and the bench.

## Interface
Parameters:
- `DATA_W`, 32, word width; must be a multiple of 8.
- `ADDR_W`, 32, byte-address width.
- `DEPTH`, 256, words in the array; power of two.
- `LATENCY`, 1, cycles from request accept to earliest response valid; 1 to 8.
- `OUTSTANDING`, 4, maximum in-flight read responses per channel; 1 to 8.
- `STARTUP_CYCLES`, 1, request-ready hold-off after reset (see Configuration).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_req_valid`  in  1  fetch request.
- `i_req_ready`  out  1  fetch request accepted when valid & ready.
- `i_req_addr`  in  ADDR_W  fetch byte address.
- `i_resp_valid`  out  1  fetch data valid.
- `i_resp_ready`  in  1  consumer accepts fetch response.
- `i_resp_data`  out  DATA_W  fetch word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted when valid & ready.
- `d_req_we`  in  1  1 = write, 0 = read.
- `d_req_addr`  in  ADDR_W  data byte address.
- `d_req_wdata`  in  DATA_W  write data.
- `d_req_be`  in  DATA_W/8  byte enables for writes.
- `d_resp_valid`  out  1  read data valid; writes produce no response.
- `d_resp_ready`  in  1  consumer accepts data response.
- `d_resp_data`  out  DATA_W  read word.

## Operation
- Word index = `addr >> log2(DATA_W/8)`, truncated modulo `DEPTH`. Low byte-offset bits are ignored. Out-of-range addresses wrap.
- Array contents are not reset. The array is preloaded by the bench through hierarchical writes or `$readmemh`.
- Read accept: the word is sampled at the accept edge, enters a `LATENCY`-stage valid/data pipe, then goes into a per-channel response FIFO of depth `OUTSTANDING`. Responses leave the FIFO in order. FIFO head = `*_resp_valid/*_resp_data`, and it pops on valid & ready.
- Per-channel in-flight counter = pipe occupancy + FIFO occupancy.
  - Increments on a read accept and decrements on a response pop. Simultaneous accept and pop leave it unchanged.
  - `*_req_ready` = (count < `OUTSTANDING`) && startup done.
- Write accept (data channel): the enabled bytes are written at the accept edge. A write does not use an in-flight slot. `d_req_ready` for a write = startup done, regardless of count.
- Ordering:
  - A data read accepted in cycle N+1 after a write accepted in cycle N returns the new data.
  - A fetch read in the same cycle as a data write to the same word returns the old data.
- Full: with count = `OUTSTANDING`, ready is low and held requests stay pending. Empty FIFO: resp_valid = 0.
- Reset mid-operation: pipes, FIFOs and counters clear immediately, and in-flight responses are discarded. The array is untouched.

## Timing
- Reset values: `i_req_ready` = `d_req_ready` = 0, `i_resp_valid` = `d_resp_valid` = 0, `i_resp_data` = `d_resp_data` = 0.
- Read accepted at edge T with the consumer ready: resp_valid rises after edge T+LATENCY−1, so it is seen at edge T+LATENCY. Each stalled response cycle adds 1.
- Throughput is one request per channel per cycle when `OUTSTANDING` > `LATENCY`. The two channels are fully independent.
- Ready deasserts in the cycle after count reaches `OUTSTANDING` and reasserts in the cycle after a pop.

## Configuration
- `MEM_STARTUP_DELAY_EN` defined: both `*_req_ready` are held 0 for `STARTUP_CYCLES` cycles after `rst_n` deasserts, counted by a saturating counter. This models slow memory bring-up.
- Undefined: ready may assert in the first cycle after reset release, and `STARTUP_CYCLES` is ignored.

## Test plan
- LATENCY=1, preload word0=0x12345678. Fetch addr 0x0 → i_resp_data=0x12345678 one edge after accept.
- Data write 0xDEADBEEF to 0x4 with be=4'b0011, word1 previously 0 → a read of 0x4 returns 0x0000BEEF. A back-to-back read in the next cycle returns the same value.
- LATENCY=3, OUTSTANDING=2, d_resp_ready=0, continuous reads → exactly 2 accepts, then ready=0. Raising resp_ready drains in order and ready returns.
- Write word 5 while fetching word 5 in the same cycle → the fetch returns the old value, and a later fetch returns the new value.
- Assert `rst_n`=0 with 2 reads in flight, then release → no response ever appears and count=0. With `MEM_STARTUP_DELAY_EN`, STARTUP_CYCLES=1, ready=0 in the first cycle after release.
- Address 0x400 with DEPTH=256 → aliases to word 0.
